// File: rtl/reload_counter_prog.sv
// -----------------------------------------------------------------------------
// reload_counter_prog
//
// Programmable reload counter for game timing (pipe spacing, gravity ticks,
// score pacing). It counts between 0 and a run-time loadable limit in either
// direction. A clock-enable prescaler divides the step rate. On each terminal
// step it either reloads or stops (one-shot). The registered terminal-count
// pulse drives the step events of the downstream game FSMs.
//
// Parameters
//   DW          counter and limit width
//   MAX_DEFAULT period after reset (reset limit = MAX_DEFAULT-1, DW bits)
//   PW          prescaler width
//
// Ports
//   clk       in   1   clock, all state on rising edge
//   rst       in   1   synchronous reset, active-low
//   en        in   1   count enable; low freezes prescaler and counter
//   load      in   1   load limit and restart (priority over en)
//   load_val  in   DW  new limit; period = load_val+1 steps
//   dir       in   1   0 = down (limit..0), 1 = up (0..limit)
//   oneshot   in   1   1 = stop at terminal value, 0 = auto-reload
//   prescale  in   PW  step every prescale+1 enabled cycles
//   count     out  DW  current value, registered
//   tc        out  1   terminal-count pulse, registered, one cycle
//   done      out  1   one-shot finished, registered, sticky
// -----------------------------------------------------------------------------
module reload_counter_prog #(
  parameter int DW          = 8,
  parameter int MAX_DEFAULT = 4,
  parameter int PW          = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          dir,
  input  logic          oneshot,
  input  logic [PW-1:0] prescale,
  output logic [DW-1:0] count,
  output logic          tc,
  output logic          done
);

  localparam logic [DW-1:0] LIMIT_RST = DW'(MAX_DEFAULT - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] limit_q, limit_d;
  logic [DW-1:0] count_q, count_d;
  logic [PW-1:0] pc_q, pc_d;
  logic          tc_q, tc_d;
  logic          done_q, done_d;

  logic          step;
  logic [DW-1:0] term_val;
  logic          at_term;

  // A prescale value lowered below the current pc still steps on the next
  // enabled cycle because the compare is >= rather than ==.
  assign step     = en && (state_q == ST_RUN) && (pc_q >= prescale);
  assign term_val = dir ? limit_q : '0;
  assign at_term  = (count_q == term_val);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    limit_d = limit_q;
    count_d = count_q;
    pc_d    = pc_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (load) begin
      // Load restarts from the start of the chosen direction; no step occurs
      // in this cycle even when en is high.
      limit_d = load_val;
      count_d = dir ? '0 : load_val;
      pc_d    = '0;
      done_d  = 1'b0;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (step) begin
            pc_d = '0;
            if (!at_term) begin
              count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
            end else if (!oneshot) begin
              count_d = dir ? '0 : limit_q;
              tc_d    = 1'b1;
            end else begin
              tc_d    = 1'b1;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end
          end else if (en) begin
            pc_d = pc_q + 1'b1;
          end
        end
        ST_DONE: begin
          // Frozen until load or reset.
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= ST_RUN;
      limit_q <= LIMIT_RST;
      count_q <= '0;
      pc_q    <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      count_q <= count_d;
      pc_q    <= pc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_reload_counter_prog.sv
// -----------------------------------------------------------------------------
// tb_reload_counter_prog
//
// Scoreboard bench for reload_counter_prog. The stimulus process drives one
// cycle at a time, advances a behavioural model and pushes the expected
// registered outputs into a queue. A monitor pops and compares after every
// rising edge. Directed sequences also compare against literal values.
// -----------------------------------------------------------------------------
module tb_reload_counter_prog;

  localparam int DW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, en, load, dir, oneshot;
  logic [DW-1:0] load_val;
  logic [PW-1:0] prescale;
  logic [DW-1:0] count;
  logic          tc, done;

  reload_counter_prog #(.DW(DW), .MAX_DEFAULT(4), .PW(PW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .oneshot  (oneshot),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] count;
    logic          tc;
    logic          done;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int  m_count, m_limit, m_wait, m_tc;
  bit  m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_wait counts enabled cycles since the last step; a step happens
  // once the wait has reached the prescale value.
  task automatic model(input bit r, ld, e, d, os, input int lv, input int ps);
    m_tc = 0;
    if (!r) begin
      m_count = 0; m_limit = 3; m_wait = 0; m_done = 0;
    end else if (ld) begin
      m_limit = lv;
      m_count = d ? 0 : lv;
      m_wait  = 0;
      m_done  = 0;
    end else if (!m_done && e) begin
      if (m_wait < ps) begin
        m_wait++;
      end else begin
        m_wait = 0;
        if (m_count == (d ? m_limit : 0)) begin
          m_tc = 1;
          if (os) m_done = 1;
          else    m_count = d ? 0 : m_limit;
        end else begin
          m_count = (m_count + (d ? 1 : -1)) & 8'hFF;
        end
      end
    end
  endtask

  task automatic cycle(input bit r, ld, e, d, os, input int lv, input int ps);
    exp_t x;
    @(negedge clk);
    rst = r; load = ld; en = e; dir = d; oneshot = os;
    load_val = lv[DW-1:0]; prescale = ps[PW-1:0];
    model(r, ld, e, d, os, lv, ps);
    x.count = m_count[DW-1:0];
    x.tc    = m_tc[0];
    x.done  = m_done;
    exp_q.push_back(x);
  endtask

  // Literal expectation for the cycle just driven.
  task automatic lit(input string tag, input int c, input int t, input int dn);
    @(posedge clk);
    #2;
    check({tag, "_count"}, int'(count), c);
    check({tag, "_tc"},    int'(tc),    t);
    check({tag, "_done"},  int'(done),  dn);
  endtask

  // Monitor: compares after every edge for which an expectation exists.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("sb_count", int'(count), int'(x.count));
        check("sb_tc",    int'(tc),    int'(x.tc));
        check("sb_done",  int'(done),  int'(x.done));
      end
    end
  end

  initial begin
    int cyc;
    bit r_d, r_os;
    int r_ps;
    rst = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; oneshot = 1'b0;
    load_val = '0; prescale = '0;

    // 1: reset defaults, down-count through limit 3.
    cycle(0, 0, 1, 0, 0, 0, 0); lit("t1_rst", 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0); lit("t1_a", 3, 1, 0);
    cycle(1, 0, 1, 0, 0, 0, 0); lit("t1_b", 2, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0); lit("t1_c", 1, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0); lit("t1_d", 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0); lit("t1_e", 3, 1, 0);

    // 2: up-count to 5.
    cycle(1, 1, 1, 1, 0, 5, 0); lit("t2_ld", 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      cycle(1, 0, 1, 1, 0, 5, 0); lit("t2_up", i, 0, 0);
    end
    cycle(1, 0, 1, 1, 0, 5, 0); lit("t2_wrap", 0, 1, 0);

    // 3: prescale 2, limit 3, en low for two cycles.
    cycle(1, 1, 1, 0, 0, 3, 2); lit("t3_ld", 3, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      cycle(1, 0, (i == 5 || i == 6) ? 1'b0 : 1'b1, 0, 0, 3, 2);
      if (i == 2)  lit("t3_hold", 3, 0, 0);
      if (i == 3)  lit("t3_step", 2, 0, 0);
      if (i == 13) lit("t3_pre", 0, 0, 0);
      if (i == 14) lit("t3_tc", 3, 1, 0);
    end

    // 4: one-shot from 2, done sticky, load clears.
    cycle(1, 1, 1, 0, 1, 2, 0); lit("t4_ld", 2, 0, 0);
    cycle(1, 0, 1, 0, 1, 2, 0); lit("t4_a", 1, 0, 0);
    cycle(1, 0, 1, 0, 1, 2, 0); lit("t4_b", 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 2, 0); lit("t4_term", 0, 1, 1);
    cycle(1, 0, 1, 0, 1, 2, 0); lit("t4_hold", 0, 0, 1);
    cycle(1, 0, 1, 0, 1, 2, 0); lit("t4_hold2", 0, 0, 1);
    cycle(1, 1, 1, 0, 1, 1, 0); lit("t4_reld", 1, 0, 0);

    // 5: load beats en; reset beats load.
    cycle(1, 1, 1, 0, 0, 4, 0); lit("t5_ld", 4, 0, 0);
    cycle(1, 0, 1, 0, 0, 4, 0); lit("t5_a", 3, 0, 0);
    cycle(1, 1, 1, 0, 0, 7, 0); lit("t5_ldwin", 7, 0, 0);
    cycle(1, 0, 1, 0, 0, 7, 0); lit("t5_pc0", 6, 0, 0);
    cycle(0, 1, 1, 0, 0, 9, 0); lit("t5_rst", 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 9, 0); lit("t5_lim", 3, 1, 0);

    // 6: limit 0, then direction flip mid-run.
    cycle(1, 1, 1, 0, 0, 0, 0); lit("t6_ld", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, 0, 0, 0, 0); lit("t6_z", 0, 1, 0);
    end
    cycle(1, 1, 1, 0, 0, 5, 0); lit("t6_ld5", 5, 0, 0);
    cycle(1, 0, 1, 0, 0, 5, 0); lit("t6_4", 4, 0, 0);
    cycle(1, 0, 1, 0, 0, 5, 0); lit("t6_3", 3, 0, 0);
    cycle(1, 0, 1, 0, 0, 5, 0); lit("t6_2", 2, 0, 0);
    cycle(1, 0, 1, 1, 0, 5, 0); lit("t6_u3", 3, 0, 0);
    cycle(1, 0, 1, 1, 0, 5, 0); lit("t6_u4", 4, 0, 0);
    cycle(1, 0, 1, 1, 0, 5, 0); lit("t6_u5", 5, 0, 0);
    cycle(1, 0, 1, 1, 0, 5, 0); lit("t6_u0", 0, 1, 0);

    // Randomized run checked only by the scoreboard.
    r_d = 0; r_os = 0; r_ps = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 15) == 0) r_d  = ~r_d;
      if ($urandom_range(0, 31) == 0) r_os = ~r_os;
      if ($urandom_range(0, 15) == 0) r_ps = $urandom_range(0, 3);
      cycle($urandom_range(0, 63) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0,
            r_d, r_os, $urandom_range(0, 12), r_ps);
    end

    @(posedge clk);
    #3;
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
